afisor_bcd_7seg: RTL and testbench

- Drives a 4-digit, common-anode, multiplexed 7-segment display from the four BCD digits produced by the stopwatch (`BCD0`..`BCD3`).
- Scans one digit per slot, decodes BCD to segments, and lights the decimal point after the minutes.
- Optionally blanks a leading minutes-tens zero, and blinks the whole display while the stopwatch is paused.
- Sits between the stopwatch top level and the board pins.

---
 rtl/afisor_bcd_7seg.sv | 141 ++++++++++++++
 tb/tb_afisor_bcd_7seg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/afisor_bcd_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : afisor_bcd_7seg
//  Description : Multiplexed driver for a 4-digit common-anode 7-segment
//                display. It scans one digit per slot, decodes BCD to
//                segments, lights the decimal point after the minutes,
//                can blank a leading minutes-tens zero, and can blink the
//                whole display.
//  Revision    : 1.0 - initial release
// ============================================================================
module afisor_bcd_7seg #(
    parameter int DIV         = 100000,
    parameter int BLANK       = 4,
    parameter int BLINK_SCANS = 125
) (
    input  logic       clk,
    input  logic       reseteaza,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic       stingere_zero,
    input  logic       clipire,
    output logic [3:0] anod,
    output logic [6:0] catod,
    output logic       dp
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [CW-1:0] C_CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] C_BLANK      = CW'(BLANK);
    localparam logic [NW-1:0] C_SCAN_LAST  = NW'(BLINK_SCANS - 1);
    localparam logic [6:0]    C_SEG_OFF    = 7'b1111111;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [NW-1:0] nscan_q, nscan_d;
    logic          faza_q, faza_d;

    logic [3:0]    anod_q, anod_d;
    logic [6:0]    catod_q, catod_d;
    logic          dp_q, dp_d;

    logic [3:0]    bcd_sel;
    logic [6:0]    seg_dec;
    logic          blank_now;

    // Select the BCD digit belonging to the slot currently being scanned
    always_comb begin
        bcd_sel = BCD0;
        case (idx_q)
            2'd0:    bcd_sel = BCD0;
            2'd1:    bcd_sel = BCD1;
            2'd2:    bcd_sel = BCD2;
            default: bcd_sel = BCD3;
        endcase
    end

    // BCD to active-low {g,f,e,d,c,b,a}; invalid codes show a dash
    always_comb begin
        seg_dec = 7'b0111111;
        case (bcd_sel)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
    end

    // Prescaler, digit index and blink counters; slot-end, scan-end and
    // blink toggle all resolve on the same edge
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        nscan_d = nscan_q;
        faza_d  = faza_q;
        if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                if (nscan_q == C_SCAN_LAST) begin
                    nscan_d = '0;
                    faza_d  = ~faza_q;
                end else begin
                    nscan_d = nscan_q + 1'b1;
                end
            end
        end
    end

    // Next output values from the current slot position and live inputs
    always_comb begin
        blank_now = (cnt_q < C_BLANK) || (clipire && faza_q);
        anod_d    = 4'b1111;
        catod_d   = C_SEG_OFF;
        dp_d      = 1'b1;
        if (!blank_now) begin
            anod_d = ~(4'b0001 << idx_q);
            dp_d   = (idx_q != 2'd2);
            if (!((idx_q == 2'd3) && stingere_zero && (BCD3 == 4'd0))) begin
                catod_d = seg_dec;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reseteaza) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            nscan_q <= '0;
            faza_q  <= 1'b0;
            anod_q  <= 4'b1111;
            catod_q <= C_SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nscan_q <= nscan_d;
            faza_q  <= faza_d;
            anod_q  <= anod_d;
            catod_q <= catod_d;
            dp_q    <= dp_d;
        end
    end

    assign anod  = anod_q;
    assign catod = catod_q;
    assign dp    = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_afisor_bcd_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_afisor_bcd_7seg
//  Description : Scoreboard bench for afisor_bcd_7seg (DIV=4, BLANK=1,
//                BLINK_SCANS=2). Stimulus pushes the expected display state
//                for every edge; a monitor pops and compares on the falling
//                edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_afisor_bcd_7seg;

    logic       clk = 1'b0;
    logic       reseteaza = 1'b1;
    logic [3:0] BCD0 = 4'd4, BCD1 = 4'd3, BCD2 = 4'd2, BCD3 = 4'd1;
    logic       stingere_zero = 1'b0;
    logic       clipire = 1'b0;
    logic [3:0] anod;
    logic [6:0] catod;
    logic       dp;

    afisor_bcd_7seg #(.DIV(4), .BLANK(1), .BLINK_SCANS(2)) dut (
        .clk           (clk),
        .reseteaza     (reseteaza),
        .BCD0          (BCD0),
        .BCD1          (BCD1),
        .BCD2          (BCD2),
        .BCD3          (BCD3),
        .stingere_zero (stingere_zero),
        .clipire       (clipire),
        .anod          (anod),
        .catod         (catod),
        .dp            (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [6:0] c;
        logic       d;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    pos      = 0;     // cycles since reset, as seen by the display
    string tag      = "reset";

    // Hand-written decode table, active-low {g..a}
    logic [6:0] dec_tab [16];
    initial begin
        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;
    end

    // One clock edge: push what the display must show after it
    task automatic step();
        exp_t e;
        int   slot, sub, ph;
        logic blk;
        logic [3:0] digit;
        e.tag = tag;
        if (reseteaza) begin
            e.a = 4'b1111; e.c = 7'b1111111; e.d = 1'b1;
        end else begin
            sub  = pos % 4;
            slot = (pos / 4) % 4;
            ph   = (pos / 32) % 2;
            blk  = (sub < 1) || (clipire && (ph == 1));
            case (slot)
                0:       digit = BCD0;
                1:       digit = BCD1;
                2:       digit = BCD2;
                default: digit = BCD3;
            endcase
            if (blk) begin
                e.a = 4'b1111; e.c = 7'b1111111; e.d = 1'b1;
            end else begin
                e.a = ~(4'b0001 << slot);
                e.d = (slot == 2) ? 1'b0 : 1'b1;
                if (slot == 3 && stingere_zero && BCD3 == 4'd0) e.c = 7'b1111111;
                else                                             e.c = dec_tab[digit];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        pos = reseteaza ? 0 : pos + 1;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compare the registered outputs once per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (anod === e.a && catod === e.c && dp === e.d) n_pass++;
                else $display("FAIL %s t=%0t: anod=%b catod=%b dp=%b, expected anod=%b catod=%b dp=%b",
                              e.tag, $time, anod, catod, dp, e.a, e.c, e.d);
            end
        end
    end

    initial begin
        // Reset held 3 cycles, then normal scanning of 4,3,2,1
        reseteaza = 1'b1; tag = "reset";
        run(3);
        reseteaza = 1'b0; tag = "scan";
        run(40);

        // Decode sweep on digit 0
        for (int v = 0; v < 16; v++) begin
            BCD0 = 4'(v); tag = $sformatf("decode_%0d", v);
            run(16);
        end

        // Leading-zero blanking on digit 3
        BCD3 = 4'd0; stingere_zero = 1'b1; tag = "lz_on";
        run(16);
        stingere_zero = 1'b0; tag = "lz_off";
        run(16);

        // Blink from reset: two full blink periods
        BCD0 = 4'd4; BCD3 = 4'd1;
        reseteaza = 1'b1; tag = "blink_rst";
        run(1);
        reseteaza = 1'b0; clipire = 1'b1; tag = "blink";
        run(128);

        // Mid-operation reset while idx=2 and faza=1
        reseteaza = 1'b1; tag = "mid_rst0";
        run(1);
        reseteaza = 1'b0; tag = "mid_pre";
        run(40);
        reseteaza = 1'b1; tag = "mid_rst";
        run(1);
        reseteaza = 1'b0; tag = "mid_post";
        run(24);

        // Live change of BCD2 while digit 2 is lit
        clipire = 1'b0; BCD2 = 4'd5; tag = "live";
        while (pos % 16 != 10) step();
        BCD2 = 4'd7;
        run(8);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
